// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// Accepts characters over a valid/ready handshake, buffers them in a circular
// FIFO and shifts them out LSB first at CLKS_PER_BIT clocks per bit.
// Optional feature: define UART_TX_CRLF_EN to expand each LF into CR LF on the line.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [7:0]                    char_in,
  input  logic                          char_in_valid,
  output logic                          char_in_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  logic [1:0]       state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;

  logic             push, pop, load;
  logic             fifo_empty, baud_done;
  logic [7:0]       head;

`ifdef UART_TX_CRLF_EN
  logic             cr_sent_q, cr_sent_d;
`endif

  assign fifo_empty    = (count_q == '0);
  assign char_in_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push          = char_in_valid && char_in_ready;
  assign head          = mem_q[rd_ptr_q];
  assign baud_done     = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  assign tx_out     = tx_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;
  assign fifo_count = count_q;

  // FIFO storage; contents are discarded on reset by clearing the pointers.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= char_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serializer next-state: start/data/stop sequencing and byte loading.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;
    load      = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_CRLF_EN
    cr_sent_d = cr_sent_q;
`endif

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (baud_done) begin
          state_d   = StData;
          baud_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = data_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_done) begin
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            baud_d  = '0;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      state_d = StStart;
      baud_d  = '0;
      tx_d    = 1'b0;
`ifdef UART_TX_CRLF_EN
      // An LF at the head first produces a CR frame and stays queued.
      if (head == 8'h0A && !cr_sent_q) begin
        data_d    = 8'h0D;
        cr_sent_d = 1'b1;
      end else begin
        data_d    = head;
        pop       = 1'b1;
        cr_sent_d = 1'b0;
      end
`else
      data_d = head;
      pop    = 1'b1;
`endif
    end
  end

  // Serializer state; reset aborts any frame and forces the line idle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_TX_CRLF_EN
  // Remembers that the CR for the LF at the head has already gone out.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cr_sent_q <= 1'b0;
    else        cr_sent_q <= cr_sent_d;
  end
`endif

endmodule
